muldiv8_host: RTL and testbench

Host-side sequencer for the 8-bit multiply/divide unit's pin protocol. It accepts a request (operation plus two 8-bit operands) on a valid/ready port and drives the unit's dedicated-input and bidirectional pins through a command beat and an operand beat. It then releases the shared bus, waits for the unit to drive its 16-bit result, and returns that result with error flags on a second valid/ready port. It sits on the far end of the unit's pins: as the board/test-harness driver, or in front of the unit wherever a bus master needs arithmetic.

---
 rtl/muldiv8_host_if.sv | 23 ++
 rtl/muldiv8_host.sv | 161 ++++++++++++++++
 tb/tb_muldiv8_host.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv8_host_if.sv
// Request/response handshake bundle between a bus master and the muldiv8 pin sequencer.
// master = requester side, slave = muldiv8_host side.
interface muldiv8_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/muldiv8_host.sv
// Host-side sequencer for the 8-bit multiply/divide unit pin protocol: command beat, operand beat,
// bus turnaround, wait for result. Optional WAIT watchdog compiled in with MULDIV8_HOST_TIMEOUT_EN.
module muldiv8_host #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  muldiv8_host_if.slave  bus,
  output logic [7:0]     pin_ui,
  output logic [7:0]     pin_uio_o,
  output logic [7:0]     pin_uio_oe_h,
  input  logic [7:0]     pin_uo,
  input  logic [7:0]     pin_uio_i,
  input  logic [7:0]     pin_uio_oe
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_OPND = 3'd2,
    ST_TURN = 3'd3,
    ST_WAIT = 3'd4,
    ST_RSP  = 3'd5
  } state_t;

  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("muldiv8_host: TIMEOUT_CYCLES out of range 1..255");
    end
  endgenerate

  function automatic logic [7:0] cmd_byte(input logic [1:0] op);
    return {1'b1, 5'b00000, op};
  endfunction

  state_t      state_r;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic        err0_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [15:0] rsp_result_r;
  logic [1:0]  rsp_err_r;
  logic [7:0]  ui_r;
  logic [7:0]  uio_o_r;
  logic [7:0]  uio_oe_h_r;
  logic        done_s;

  // Unit signals completion only with every uio lane enabled; partial enables are ignored.
  assign done_s = (pin_uio_oe == 8'hFF);

`ifdef MULDIV8_HOST_TIMEOUT_EN
  localparam logic [8:0] TIMEOUT_LIMIT_C = 9'(TIMEOUT_CYCLES);
  logic [7:0] wd_cnt_r;
  logic       wd_hit_s;
  assign wd_hit_s = (({1'b0, wd_cnt_r} + 9'd1) == TIMEOUT_LIMIT_C);
`endif

  // Transaction sequencer with registered pin and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      a_r          <= 8'h00;
      b_r          <= 8'h00;
      err0_r       <= 1'b0;
      req_ready_r  <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= 16'h0000;
      rsp_err_r    <= 2'b00;
      ui_r         <= 8'h00;
      uio_o_r      <= 8'h00;
      uio_oe_h_r   <= 8'h00;
`ifdef MULDIV8_HOST_TIMEOUT_EN
      wd_cnt_r     <= 8'h00;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          req_ready_r <= 1'b1;
          if (req_ready_r && bus.req_valid) begin
            a_r         <= bus.req_a;
            b_r         <= bus.req_b;
            err0_r      <= bus.req_op[1] & (bus.req_b == 8'h00);
            ui_r        <= cmd_byte(bus.req_op);
            uio_o_r     <= 8'h00;
            uio_oe_h_r  <= 8'h00;
            req_ready_r <= 1'b0;
            state_r     <= ST_CMD;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_CMD: begin
          ui_r       <= a_r;
          uio_o_r    <= b_r;
          uio_oe_h_r <= 8'hFF;
          state_r    <= ST_OPND;
        end
        ST_OPND: begin
          ui_r       <= 8'h00;
          uio_o_r    <= 8'h00;
          uio_oe_h_r <= 8'h00;
          state_r    <= ST_TURN;
        end
        ST_TURN: begin
`ifdef MULDIV8_HOST_TIMEOUT_EN
          wd_cnt_r <= 8'h00;
`endif
          state_r  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_s) begin
            rsp_result_r <= {pin_uio_i, pin_uo};
            rsp_err_r    <= {1'b0, err0_r};
            rsp_valid_r  <= 1'b1;
            state_r      <= ST_RSP;
`ifdef MULDIV8_HOST_TIMEOUT_EN
          end else if (wd_hit_s) begin
            rsp_result_r <= 16'hFFFF;
            rsp_err_r    <= {1'b1, err0_r};
            rsp_valid_r  <= 1'b1;
            state_r      <= ST_RSP;
          end else begin
            wd_cnt_r     <= wd_cnt_r + 8'd1;
          end
`else
          end else begin
            state_r      <= ST_WAIT;
          end
`endif
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_RSP;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b0;
          ui_r        <= 8'h00;
          uio_o_r     <= 8'h00;
          uio_oe_h_r  <= 8'h00;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_err    = rsp_err_r;
  assign pin_ui         = ui_r;
  assign pin_uio_o      = uio_o_r;
  assign pin_uio_oe_h   = uio_oe_h_r;

endmodule

// File: tb/tb_muldiv8_host.sv
// Directed bench for muldiv8_host with a behavioural model of the arithmetic unit on the pins.
// Timeout expectations follow MULDIV8_HOST_TIMEOUT_EN.
module tb_muldiv8_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pin_ui;
  logic [7:0] pin_uio_o;
  logic [7:0] pin_uio_oe_h;
  logic [7:0] pin_uo = 8'h00;
  logic [7:0] pin_uio_i = 8'h00;
  logic [7:0] pin_uio_oe = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv8_host_if bus ();

  muldiv8_host #(.TIMEOUT_CYCLES(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .pin_ui       (pin_ui),
    .pin_uio_o    (pin_uio_o),
    .pin_uio_oe_h (pin_uio_oe_h),
    .pin_uo       (pin_uo),
    .pin_uio_i    (pin_uio_i),
    .pin_uio_oe   (pin_uio_oe)
  );

  always #5 clk = ~clk;

  // Unit model: lat cycles of WAIT before a one-cycle full-enable result; 0 = never respond.
  int          m_lat = 1;
  logic        m_ovr_en = 1'b0;
  logic [15:0] m_ovr = 16'h0000;
  int          m_cnt = 0;
  logic [1:0]  m_op = 2'd0;
  logic [7:0]  m_a = 8'h00;
  logic [7:0]  m_b = 8'h00;

  function automatic logic [15:0] unit_calc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, p, q, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      2'd0: p = int'(a) * int'(b);
      2'd1: p = sa * sb;
      2'd2: begin
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        p = (r << 8) | (q & 255);
      end
      default: begin
        q = sa / sb;
        r = sa % sb;
        p = ((r & 255) << 8) | (q & 255);
      end
    endcase
    return p[15:0];
  endfunction

  always @(negedge clk) begin
    logic [15:0] res;
    if (!rst_n) begin
      m_cnt = 0;
      pin_uo = 8'h00; pin_uio_i = 8'h00; pin_uio_oe = 8'h00;
    end else if (pin_uio_oe_h == 8'hFF) begin
      m_a = pin_ui; m_b = pin_uio_o;
      m_cnt = (m_lat > 0) ? m_lat + 1 : 0;
      pin_uo = 8'h00; pin_uio_i = 8'h00; pin_uio_oe = 8'h00;
    end else if (pin_ui[7] && pin_ui[6:2] == 5'd0 && pin_uio_oe_h == 8'h00) begin
      m_op = pin_ui[1:0];
      pin_uo = 8'h00; pin_uio_i = 8'h00; pin_uio_oe = 8'h00;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        res = m_ovr_en ? m_ovr : unit_calc(m_op, m_a, m_b);
        pin_uo = res[7:0]; pin_uio_i = res[15:8]; pin_uio_oe = 8'hFF;
      end else begin
        pin_uo = 8'hEE; pin_uio_i = 8'hEE; pin_uio_oe = 8'h7F;
      end
    end else begin
      pin_uo = 8'h00; pin_uio_i = 8'h00; pin_uio_oe = 8'h00;
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    int          lat;
    logic        ovr_en;
    logic [15:0] ovr;
    int          stall;
    int          exp_cyc;
    logic [15:0] exp_res;
    logic [1:0]  exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge where rsp_valid is first seen.
  task automatic start_txn(input vec_t v, output int cyc);
    int n;
    m_lat = v.lat; m_ovr_en = v.ovr_en; m_ovr = v.ovr;
    bus.req_op = v.op; bus.req_a = v.a; bus.req_b = v.b; bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("cmd_ui", 32'(pin_ui), 32'(8'h80 | 8'(v.op)));
    chk("cmd_oe_h", 32'(pin_uio_oe_h), 32'h00);
    chk("busy_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    chk("opnd_ui", 32'(pin_ui), 32'(v.a));
    chk("opnd_uio", 32'(pin_uio_o), 32'(v.b));
    chk("opnd_oe_h", 32'(pin_uio_oe_h), 32'hFF);
    @(posedge clk); #1;
    chk("turn_oe_h", 32'(pin_uio_oe_h), 32'h00);
    chk("turn_ui", 32'(pin_ui), 32'h00);
    cyc = 2;
    while (!bus.rsp_valid && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    chk("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic finish_txn(input vec_t v);
    chk("rsp_result", 32'(bus.rsp_result), 32'(v.exp_res));
    chk("rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
    if (v.stall > 0) begin
      bus.req_op = 2'd1; bus.req_a = 8'h12; bus.req_b = 8'h34; bus.req_valid = 1'b1;
    end
    for (int i = 0; i < v.stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_result", 32'(bus.rsp_result), 32'(v.exp_res));
      chk("stall_refuse", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_hs_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ui"}, 32'(pin_ui), 32'h00);
    chk({tag, "_uio"}, 32'(pin_uio_o), 32'h00);
    chk({tag, "_oe_h"}, 32'(pin_uio_oe_h), 32'h00);
    chk({tag, "_rspv"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_res"}, 32'(bus.rsp_result), 32'h0000);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [10];
    vec_t v;
    int   cyc;
    bit   saw;

    vt[0] = '{op:2'd0, a:8'h0F, b:8'h11, lat:3, ovr_en:1'b0, ovr:16'h0000, stall:0, exp_cyc:6, exp_res:16'h00FF, exp_err:2'b00};
    vt[1] = '{op:2'd1, a:8'hFF, b:8'h02, lat:1, ovr_en:1'b0, ovr:16'h0000, stall:0, exp_cyc:4, exp_res:16'hFFFE, exp_err:2'b00};
    vt[2] = '{op:2'd2, a:8'hC8, b:8'h07, lat:2, ovr_en:1'b0, ovr:16'h0000, stall:5, exp_cyc:5, exp_res:16'h041C, exp_err:2'b00};
    vt[3] = '{op:2'd3, a:8'h05, b:8'h00, lat:2, ovr_en:1'b1, ovr:16'hABCD, stall:0, exp_cyc:5, exp_res:16'hABCD, exp_err:2'b01};
    vt[4] = '{op:2'd3, a:8'h9C, b:8'h07, lat:1, ovr_en:1'b0, ovr:16'h0000, stall:0, exp_cyc:4, exp_res:16'hFEF2, exp_err:2'b00};
    vt[5] = '{op:2'd1, a:8'h80, b:8'h80, lat:4, ovr_en:1'b0, ovr:16'h0000, stall:0, exp_cyc:7, exp_res:16'h4000, exp_err:2'b00};
    vt[6] = '{op:2'd2, a:8'hFF, b:8'h10, lat:1, ovr_en:1'b0, ovr:16'h0000, stall:0, exp_cyc:4, exp_res:16'h0F0F, exp_err:2'b00};
    vt[7] = '{op:2'd2, a:8'h10, b:8'h00, lat:1, ovr_en:1'b1, ovr:16'h1234, stall:0, exp_cyc:4, exp_res:16'h1234, exp_err:2'b01};
    vt[8] = '{op:2'd0, a:8'h00, b:8'h00, lat:2, ovr_en:1'b0, ovr:16'h0000, stall:0, exp_cyc:5, exp_res:16'h0000, exp_err:2'b00};
    vt[9] = '{op:2'd0, a:8'hFF, b:8'hFF, lat:1, ovr_en:1'b0, ovr:16'h0000, stall:0, exp_cyc:4, exp_res:16'hFE01, exp_err:2'b00};

    bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_a = 8'h00; bus.req_b = 8'h00; bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    release_reset();

    foreach (vt[i]) begin
      start_txn(vt[i], cyc);
      chk($sformatf("latency_v%0d", i), 32'(cyc), 32'(vt[i].exp_cyc));
      finish_txn(vt[i]);
    end

`ifdef MULDIV8_HOST_TIMEOUT_EN
    v = '{op:2'd2, a:8'h21, b:8'h00, lat:0, ovr_en:1'b0, ovr:16'h0000, stall:0, exp_cyc:67, exp_res:16'hFFFF, exp_err:2'b11};
    start_txn(v, cyc);
    chk("timeout_latency", 32'(cyc), 32'd67);
    finish_txn(v);
`endif

    // Unit never answers; host must sit in WAIT until reset.
    v = '{op:2'd0, a:8'h07, b:8'h09, lat:0, ovr_en:1'b0, ovr:16'h0000, stall:0, exp_cyc:0, exp_res:16'h0000, exp_err:2'b00};
    m_lat = 0;
    bus.req_op = v.op; bus.req_a = v.a; bus.req_b = v.b; bus.req_valid = 1'b1;
    while (!bus.req_ready) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    saw = 1'b0;
`ifdef MULDIV8_HOST_TIMEOUT_EN
    for (int i = 0; i < 20; i++) begin
`else
    for (int i = 0; i < 1000; i++) begin
`endif
      @(posedge clk); #1;
      if (bus.rsp_valid || bus.req_ready) saw = 1'b1;
    end
    chk("hang_in_wait", 32'(saw), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_wait");
    release_reset();

    // Reset during the operand beat clears the driven pins immediately.
    m_lat = 0;
    bus.req_op = 2'd0; bus.req_a = 8'hAA; bus.req_b = 8'h55; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("opnd_pre_rst", 32'(pin_uio_oe_h), 32'hFF);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_opnd");
    release_reset();

    // Reset while a response with error flags is held.
    start_txn(vt[3], cyc);
    chk("rsp_pre_rst", 32'(bus.rsp_err), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_rsp");
    release_reset();

    v = '{op:2'd0, a:8'h03, b:8'h05, lat:1, ovr_en:1'b0, ovr:16'h0000, stall:0, exp_cyc:4, exp_res:16'h000F, exp_err:2'b00};
    start_txn(v, cyc);
    chk("recover_latency", 32'(cyc), 32'd4);
    finish_txn(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
